// File: rtl/ddr_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_wr_pkg
// Description : Shared FSM encoding, word geometry and the burst-address
//               helper used by the ddr_wr_packer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr_wr_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        DATA     = 2'd2,
        WAIT_FIN = 2'd3
    } state_e;

    localparam int unsigned c_PIX_PER_WORD = 8;
    localparam int unsigned c_PIX_W        = 16;
    localparam int unsigned c_BEAT_W       = 128;
    localparam int unsigned c_ADDR_W       = 21;

    // Next burst start; wraps to 0 when the following burst would pass max_addr.
    function automatic logic [c_ADDR_W-1:0] next_burst_addr(
        input logic [c_ADDR_W-1:0] addr,
        input logic [c_ADDR_W-1:0] max_addr,
        input int unsigned         step
    );
        logic [c_ADDR_W+1:0] w_stp;
        logic [c_ADDR_W+1:0] w_nxt;
        w_stp = (c_ADDR_W+2)'(step);
        w_nxt = {2'b00, addr} + w_stp;
        if ((w_nxt + w_stp) > {2'b00, max_addr}) begin
            return '0;
        end
        return w_nxt[c_ADDR_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_sa.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_sa
// Description : Single-clock show-ahead FIFO. i_clr truncates the contents to
//               the i_keep oldest words remaining after this cycle's pop.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_sa #(
    parameter  int WIDTH = 128,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic             i_clr,
    input  logic [CW-1:0]    i_keep,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [AW-1:0]    r_wr_ptr_q, w_wr_ptr_d;
    logic [AW-1:0]    r_rd_ptr_q, w_rd_ptr_d;
    logic [CW-1:0]    r_cnt_q, w_cnt_d;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_cnt_q == CW'(DEPTH));
    assign o_empty = (r_cnt_q == '0);
    assign o_count = r_cnt_q;
    assign w_push  = i_wr_en && !o_full && !i_clr;
    assign w_pop   = i_rd_en && !o_empty;

    always_comb begin
        w_rd_ptr_d = r_rd_ptr_q + AW'(w_pop);
        w_wr_ptr_d = r_wr_ptr_q + AW'(w_push);
        w_cnt_d    = r_cnt_q + CW'(w_push) - CW'(w_pop);
        if (i_clr) begin
            w_wr_ptr_d = w_rd_ptr_d + i_keep[AW-1:0];
            w_cnt_d    = i_keep;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_cnt_q    <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_cnt_q    <= w_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr_q] <= i_wr_data;
        end
    end

    assign o_rd_data = o_empty ? '0 : r_mem_q[r_rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/ddr_wr_packer.sv
`default_nettype none
// ============================================================================
// Module      : ddr_wr_packer
// Description : Packs 16-bit pixels into 128-bit words, buffers them and
//               issues fixed-length DDR write bursts. DDR_WR_OVF_CNT_EN
//               enables the saturating dropped-word counter on ovf_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_wr_packer
    import ddr_wr_pkg::*;
#(
    parameter int BURST_LEN  = 64,
    parameter int FIFO_DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic [20:0]   ddr_max_addr,
    input  logic          ddr_wr_en,
    input  logic [15:0]   ddr_wr_data,
    output logic          wr_burst_req,
    input  logic          wr_burst_ack,
    output logic [20:0]   wr_burst_addr,
    input  logic          wr_data_req,
    output logic [127:0]  wr_data,
    input  logic          wr_burst_finish,
    output logic          ovf,
    output logic [15:0]   ovf_cnt
);

    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam int          PW          = $clog2(c_PIX_PER_WORD);
    localparam logic [CW-1:0] c_BURST_CNT = CW'(BURST_LEN);
    localparam int unsigned c_BURST_PIX = BURST_LEN * c_PIX_PER_WORD;

    state_e                                 r_state_q, w_state_d;
    logic [PW-1:0]                          r_pos_q, w_pos_d, w_pos_base;
    logic [c_PIX_PER_WORD-1:0][c_PIX_W-1:0] r_pix_q, w_pix_d;
    logic                                   r_push_q, w_push_d;
    logic [c_BEAT_W-1:0]                    r_push_data_q, w_push_data_d;
    logic [c_ADDR_W-1:0]                    r_addr_q, w_addr_d;
    logic [CW-1:0]                          r_beat_q, w_beat_d;
    logic                                   r_restart_q, w_restart_d;
    logic                                   r_ovf_q, w_ovf_d;
    logic                                   w_fifo_full, w_fifo_empty;
    logic [CW-1:0]                          w_fifo_cnt, w_keep;
    logic                                   w_pop, w_drop;

    assign w_pop  = (r_state_q == DATA) && wr_data_req && !w_fifo_empty;
    assign w_drop = r_push_q && w_fifo_full && !frame_start;

    // A coincident pixel on frame_start lands in slot 0 of the new frame.
    always_comb begin
        w_pos_base    = frame_start ? '0 : r_pos_q;
        w_pix_d       = r_pix_q;
        w_pos_d       = w_pos_base;
        w_push_d      = 1'b0;
        w_push_data_d = r_push_data_q;
        if (ddr_wr_en) begin
            w_pix_d[w_pos_base] = ddr_wr_data;
            w_pos_d             = w_pos_base + PW'(1);
            if (w_pos_base == PW'(c_PIX_PER_WORD - 1)) begin
                w_push_d      = 1'b1;
                w_push_data_d = w_pix_d;
            end
        end
    end

    // On frame_start mid-burst keep only the words the open burst still owes.
    always_comb begin
        case (r_state_q)
            REQ:     w_keep = c_BURST_CNT;
            DATA:    w_keep = c_BURST_CNT - r_beat_q - CW'(w_pop);
            default: w_keep = '0;
        endcase
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_beat_d    = r_beat_q;
        w_addr_d    = r_addr_q;
        w_restart_d = r_restart_q | (frame_start && (r_state_q != IDLE));
        w_ovf_d     = frame_start ? 1'b0 : (r_ovf_q | w_drop);
        case (r_state_q)
            IDLE: begin
                if (frame_start) begin
                    w_addr_d = '0;
                end else if (w_fifo_cnt >= c_BURST_CNT) begin
                    w_state_d = REQ;
                end
            end
            REQ: begin
                if (wr_burst_ack) begin
                    w_state_d = DATA;
                    w_beat_d  = '0;
                end
            end
            DATA: begin
                if (w_pop) begin
                    w_beat_d = r_beat_q + CW'(1);
                    if (r_beat_q == (c_BURST_CNT - CW'(1))) begin
                        w_state_d = WAIT_FIN;
                    end
                end
            end
            WAIT_FIN: begin
                if (wr_burst_finish) begin
                    w_state_d   = IDLE;
                    w_restart_d = 1'b0;
                    w_addr_d    = (r_restart_q || frame_start) ? '0 :
                                  next_burst_addr(r_addr_q, ddr_max_addr, c_BURST_PIX);
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= IDLE;
            r_pos_q       <= '0;
            r_pix_q       <= '0;
            r_push_q      <= 1'b0;
            r_push_data_q <= '0;
            r_addr_q      <= '0;
            r_beat_q      <= '0;
            r_restart_q   <= 1'b0;
            r_ovf_q       <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_pos_q       <= w_pos_d;
            r_pix_q       <= w_pix_d;
            r_push_q      <= w_push_d;
            r_push_data_q <= w_push_data_d;
            r_addr_q      <= w_addr_d;
            r_beat_q      <= w_beat_d;
            r_restart_q   <= w_restart_d;
            r_ovf_q       <= w_ovf_d;
        end
    end

    sync_fifo_sa #(
        .WIDTH (c_BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (r_push_q),
        .i_wr_data (r_push_data_q),
        .i_rd_en   (w_pop),
        .i_clr     (frame_start),
        .i_keep    (w_keep),
        .o_rd_data (wr_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_cnt)
    );

    assign wr_burst_req  = (r_state_q == REQ);
    assign wr_burst_addr = r_addr_q;
    assign ovf           = r_ovf_q;

`ifdef DDR_WR_OVF_CNT_EN
    logic [15:0] r_ovf_cnt_q, w_ovf_cnt_d;

    always_comb begin
        w_ovf_cnt_d = r_ovf_cnt_q;
        if (w_drop && (r_ovf_cnt_q != 16'hFFFF)) begin
            w_ovf_cnt_d = r_ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_cnt_q <= '0;
        end else begin
            r_ovf_cnt_q <= w_ovf_cnt_d;
        end
    end

    assign ovf_cnt = r_ovf_cnt_q;
`else
    assign ovf_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr_wr_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_wr_packer
// Description : Directed self-checking bench for ddr_wr_packer; expected
//               ovf_cnt follows DDR_WR_OVF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_wr_packer;
    import ddr_wr_pkg::*;

    localparam int BL = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic [20:0]   ddr_max_addr = 21'h1FFFFF;
    logic          ddr_wr_en = 1'b0;
    logic [15:0]   ddr_wr_data = 16'd0;
    logic          wr_burst_req;
    logic          wr_burst_ack = 1'b1;
    logic [20:0]   wr_burst_addr;
    logic          wr_data_req = 1'b1;
    logic [127:0]  wr_data;
    logic          wr_burst_finish = 1'b1;
    logic          ovf;
    logic [15:0]   ovf_cnt;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            pix = 0;
    int            beats_left = 0;
    logic [127:0]  beats [$];
    logic [20:0]   addrs [$];
    logic [15:0]   exp_ovf_cnt;

    ddr_wr_packer dut (
        .clk             (clk),
        .rst             (rst),
        .frame_start     (frame_start),
        .ddr_max_addr    (ddr_max_addr),
        .ddr_wr_en       (ddr_wr_en),
        .ddr_wr_data     (ddr_wr_data),
        .wr_burst_req    (wr_burst_req),
        .wr_burst_ack    (wr_burst_ack),
        .wr_burst_addr   (wr_burst_addr),
        .wr_data_req     (wr_data_req),
        .wr_data         (wr_data),
        .wr_burst_finish (wr_burst_finish),
        .ovf             (ovf),
        .ovf_cnt         (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_word(input int base);
        logic [127:0] w;
        for (int i = 0; i < 8; i++) w[i*16 +: 16] = 16'(base + i);
        return w;
    endfunction

    function automatic logic [127:0] beat_at(input int i);
        if (i < beats.size()) return beats[i];
        return 'x;
    endfunction

    function automatic logic [127:0] addr_at(input int i);
        if (i < addrs.size()) return 128'(addrs[i]);
        return 'x;
    endfunction

    // One clock; a request seen with ack before the edge opens a beat window.
    task automatic cyc();
        logic        fire;
        logic [20:0] a;
        fire = wr_burst_req && wr_burst_ack;
        a    = wr_burst_addr;
        @(posedge clk);
        #1;
        if (fire) begin
            addrs.push_back(a);
            beats_left = BL;
        end
        if (beats_left > 0) begin
            beats.push_back(wr_data);
            beats_left--;
        end
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            ddr_wr_en   = 1'b1;
            ddr_wr_data = 16'(pix);
            pix++;
            cyc();
        end
        ddr_wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_start = 1'b0;
        ddr_wr_en = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        beats.delete();
        addrs.delete();
        beats_left = 0;
        pix = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no completion, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef DDR_WR_OVF_CNT_EN
        exp_ovf_cnt = 16'd6;
`else
        exp_ovf_cnt = 16'd0;
`endif
        // Reset state
        do_reset();
        check("rst_req",  128'(wr_burst_req),  128'd0);
        check("rst_addr", 128'(wr_burst_addr), 128'd0);
        check("rst_ovf",  128'(ovf),           128'd0);
        check("rst_ocnt", 128'(ovf_cnt),       128'd0);
        check("rst_data", wr_data,             128'd0);

        // One burst of pixels 0..511
        feed(512);
        idle(80);
        check("s1_nreq",  128'(addrs.size()), 128'd1);
        check("s1_addr0", addr_at(0), 128'd0);
        check("s1_nbeat", 128'(beats.size()), 128'd64);
        check("s1_beat0", beat_at(0),  128'h0007_0006_0005_0004_0003_0002_0001_0000);
        check("s1_beat63", beat_at(63), 128'h01FF_01FE_01FD_01FC_01FB_01FA_01F9_01F8);
        for (int i = 0; i < BL; i++) check($sformatf("s1_beat%0d", i), beat_at(i), exp_word(8 * i));
        check("s1_next",  128'(wr_burst_addr), 128'd512);
        check("s1_req0",  128'(wr_burst_req),  128'd0);
        check("s1_empty", wr_data, 128'd0);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        check("s1_fs_idle_addr", 128'(wr_burst_addr), 128'd0);

        // Wrap at ddr_max_addr = 1024
        do_reset();
        ddr_max_addr = 21'd1024;
        feed(1536);
        idle(120);
        check("s2_nreq",  128'(addrs.size()), 128'd3);
        check("s2_addr0", addr_at(0), 128'd0);
        check("s2_addr1", addr_at(1), 128'd512);
        check("s2_addr2", addr_at(2), 128'd0);
        check("s2_nbeat", 128'(beats.size()), 128'd192);
        check("s2_b64",   beat_at(64),  exp_word(512));
        check("s2_b191",  beat_at(191), exp_word(1528));
        check("s2_next",  128'(wr_burst_addr), 128'd512);

        // Overflow with ack withheld
        do_reset();
        ddr_max_addr = 21'h1FFFFF;
        wr_burst_ack = 1'b0;
        feed(2100);
        idle(4);
        check("s3_ovf",   128'(ovf),          128'd1);
        check("s3_ocnt",  128'(ovf_cnt),      128'(exp_ovf_cnt));
        check("s3_req",   128'(wr_burst_req), 128'd1);
        check("s3_count", 128'(dut.u_fifo.o_count), 128'd256);
        check("s3_head",  wr_data, exp_word(0));
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        check("s3_fs_ovf",  128'(ovf),     128'd0);
        check("s3_fs_ocnt", 128'(ovf_cnt), 128'(exp_ovf_cnt));
        wr_burst_ack = 1'b1;
        idle(80);
        check("s3_nbeat", 128'(beats.size()), 128'd64);
        check("s3_b0",    beat_at(0),  exp_word(0));
        check("s3_b63",   beat_at(63), exp_word(504));
        check("s3_addr",  128'(wr_burst_addr), 128'd0);
        check("s3_empty", wr_data, 128'd0);

        // Partial word discarded by frame_start; coincident pixel is pixel 0
        do_reset();
        pix = 16'hA0;
        feed(5);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        pix = 16'h10;
        feed(8);
        idle(3);
        check("s4_word", wr_data, exp_word(16'h10));
        pix = 16'h50;
        feed(3);
        frame_start = 1'b1;
        ddr_wr_en   = 1'b1;
        ddr_wr_data = 16'h20;
        cyc();
        frame_start = 1'b0;
        pix = 16'h21;
        feed(7);
        idle(3);
        check("s4_coinc", wr_data, exp_word(16'h20));
        check("s4_count", 128'(dut.u_fifo.o_count), 128'd1);

        // frame_start during DATA: burst finishes, extra word dropped, addr 0
        do_reset();
        feed(520);
        for (int i = 0; i < 200 && beats.size() < 10; i++) cyc();
        check("s5_wait", 128'(beats.size() >= 10), 128'd1);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        idle(70);
        check("s5_nbeat", 128'(beats.size()), 128'd64);
        for (int i = 0; i < BL; i++) check($sformatf("s5_beat%0d", i), beat_at(i), exp_word(8 * i));
        check("s5_addr",  128'(wr_burst_addr), 128'd0);
        check("s5_empty", wr_data, 128'd0);

        // rst mid-burst
        do_reset();
        feed(512);
        for (int i = 0; i < 200 && beats.size() < 5; i++) cyc();
        check("s6_wait", 128'(beats.size() >= 5), 128'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        beats_left = 0;
        check("s6_req",   128'(wr_burst_req), 128'd0);
        check("s6_state", 128'(dut.r_state_q), 128'(IDLE));
        check("s6_empty", wr_data, 128'd0);
        check("s6_count", 128'(dut.u_fifo.o_count), 128'd0);
        idle(10);
        check("s6_req_later", 128'(wr_burst_req), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
